// File: rtl/cpl_rob_pkg.sv
// Shared types and defaults for the completion reorder buffer.
// Optional build macro used by the top: CPL_ROB_ERR_CNT_EN.
package cpl_rob_pkg;

   localparam int ROB_TAG_W      = 3;
   localparam int ROB_SLOT_BEATS = 8;
   localparam int ROB_IDX_W      = $clog2(ROB_SLOT_BEATS);
   localparam int ROB_BEAT_W     = 128 + 4;

   typedef struct packed {
      logic                 busy;
      logic                 complete;
      logic [ROB_IDX_W:0]   expected;
      logic [ROB_IDX_W-1:0] wr_idx;
   } slot_t;

   // Out-of-range requests are given a full-size slot.
   function automatic logic [ROB_IDX_W:0] norm_beats(input logic [3:0] beats);
      logic [ROB_IDX_W:0] res;
      if (beats == 4'd0 || beats > 4'(ROB_SLOT_BEATS)) begin
         res = (ROB_IDX_W+1)'(ROB_SLOT_BEATS);
      end else begin
         res = (ROB_IDX_W+1)'(beats);
      end
      return res;
   endfunction

endpackage

// File: rtl/cpl_rob_ram.sv
// Simple dual-port beat store: synchronous write, one-cycle registered read.
// Contents are deliberately not reset.
module cpl_rob_ram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 132
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/cpl_reorder_buffer.sv
// Tag-indexed completion reorder buffer: issues tags in order, stores beats per
// tag, streams requests out in allocation order. Macro CPL_ROB_ERR_CNT_EN adds err_count.
module cpl_reorder_buffer
   import cpl_rob_pkg::*;
#(
   parameter int TAG_W      = ROB_TAG_W,
   parameter int SLOT_BEATS = ROB_SLOT_BEATS
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         alloc_valid,
   input  logic [3:0]   alloc_beats,
   output logic         alloc_ready,
   output logic [7:0]   alloc_tag,
   input  logic [127:0] din,
   input  logic         din_valid,
   input  logic [3:0]   din_dwen,
   input  logic         din_done,
   input  logic [7:0]   din_tag,
   output logic [127:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic [3:0]   dout_dwen,
   output logic         dout_last,
   output logic         err_unexpected
`ifdef CPL_ROB_ERR_CNT_EN
   ,output logic [15:0] err_count
`endif
);

   localparam int SLOTS = 1 << TAG_W;
   localparam int IDX_W = $clog2(SLOT_BEATS);
   localparam int AW    = TAG_W + IDX_W;

   slot_t                 slots [SLOTS];
   logic [TAG_W-1:0]      alloc_ptr, rd_head, free_head, wr_slot;
   logic [IDX_W-1:0]      rd_idx;
   logic [TAG_W:0]        count;
   logic                  grant, drop, wr_en, head_last, issue, pop, free;
   logic                  rq_valid, rq_last, skid_valid, skid_last, out_last;
   logic                  q_remains, skid_remains;
   logic [ROB_BEAT_W-1:0] ram_q, skid_data, out_beat;
   logic                  unused_done;

   assign unused_done = din_done;
   assign alloc_ready = (count < (TAG_W+1)'(SLOTS));
   assign alloc_tag   = {{(8-TAG_W){1'b0}}, alloc_ptr};
   assign grant       = alloc_valid & alloc_ready;

   assign wr_slot   = din_tag[TAG_W-1:0];
   assign drop      = (|din_tag[7:TAG_W]) | ~slots[wr_slot].busy | slots[wr_slot].complete;
   assign wr_en     = din_valid & ~drop;
   assign head_last = ((IDX_W+1)'(rd_idx) + (IDX_W+1)'(1)) == slots[rd_head].expected;

   // dout_valid/dout_ready: a beat transfers on a cycle where both are high; while
   // dout_valid is high and dout_ready low, dout/dout_dwen/dout_last hold steady.
   // The RAM read register and the skid register form a 2-entry output queue,
   // skid being the older entry whenever both are occupied.
   assign pop          = dout_valid & dout_ready;
   assign q_remains    = rq_valid & ~(pop & ~skid_valid);
   assign skid_remains = skid_valid & ~pop;
   assign issue        = slots[rd_head].complete & ~(q_remains & skid_remains);
   assign free         = pop & out_last;

   always_comb begin
      out_beat = '0;
      out_last = 1'b0;
      if (skid_valid) begin
         out_beat = skid_data;
         out_last = skid_last;
      end else if (rq_valid) begin
         out_beat = ram_q;
         out_last = rq_last;
      end
   end

   assign dout_valid = skid_valid | rq_valid;
   assign dout       = out_beat[ROB_BEAT_W-1:4];
   assign dout_dwen  = out_beat[3:0];
   assign dout_last  = out_last;

   cpl_rob_ram #(.ADDR_W(AW), .DATA_W(ROB_BEAT_W)) u_ram (
      .clk   (i_clk),
      .we    (wr_en),
      .waddr ({wr_slot, slots[wr_slot].wr_idx}),
      .wdata ({din, din_dwen}),
      .re    (issue),
      .raddr ({rd_head, rd_idx}),
      .rdata (ram_q)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
         alloc_ptr      <= '0;
         rd_head        <= '0;
         free_head      <= '0;
         rd_idx         <= '0;
         count          <= '0;
         err_unexpected <= 1'b0;
      end else begin
         if (grant) begin
            slots[alloc_ptr] <= '{busy: 1'b1, complete: 1'b0,
                                  expected: norm_beats(alloc_beats), wr_idx: '0};
            alloc_ptr        <= alloc_ptr + TAG_W'(1);
         end
         if (wr_en) begin
            slots[wr_slot].wr_idx <= slots[wr_slot].wr_idx + IDX_W'(1);
            if (((IDX_W+1)'(slots[wr_slot].wr_idx) + (IDX_W+1)'(1)) == slots[wr_slot].expected)
               slots[wr_slot].complete <= 1'b1;
         end
         if (free) begin
            slots[free_head].busy     <= 1'b0;
            slots[free_head].complete <= 1'b0;
            free_head                 <= free_head + TAG_W'(1);
         end
         // Read pointer runs ahead of the free pointer so slots stream without bubbles.
         if (issue) begin
            if (head_last) begin
               rd_idx  <= '0;
               rd_head <= rd_head + TAG_W'(1);
            end else begin
               rd_idx  <= rd_idx + IDX_W'(1);
            end
         end
         case ({grant, free})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
         endcase
         err_unexpected <= din_valid & drop;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rq_valid   <= 1'b0;
         rq_last    <= 1'b0;
         skid_valid <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= '0;
      end else begin
         if (issue) begin
            rq_valid <= 1'b1;
            rq_last  <= head_last;
         end else begin
            rq_valid <= q_remains;
         end
         if (issue && q_remains) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= rq_last;
         end else begin
            skid_valid <= skid_remains;
         end
      end
   end

`ifdef CPL_ROB_ERR_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_count <= '0;
      end else if (din_valid && drop && err_count != 16'hFFFF) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpl_reorder_buffer.sv
// Bench for cpl_reorder_buffer: vector table for in-order/error/dwen cases plus
// hand sequences for backpressure, mid-stream reset and full occupancy.
module tb_cpl_reorder_buffer;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         alloc_valid;
   logic [3:0]   alloc_beats;
   logic         alloc_ready;
   logic [7:0]   alloc_tag;
   logic [127:0] din;
   logic         din_valid;
   logic [3:0]   din_dwen;
   logic         din_done;
   logic [7:0]   din_tag;
   logic [127:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic [3:0]   dout_dwen;
   logic         dout_last;
   logic         err_unexpected;
`ifdef CPL_ROB_ERR_CNT_EN
   logic [15:0]  err_count;
`endif

   cpl_reorder_buffer dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .alloc_valid    (alloc_valid),
      .alloc_beats    (alloc_beats),
      .alloc_ready    (alloc_ready),
      .alloc_tag      (alloc_tag),
      .din            (din),
      .din_valid      (din_valid),
      .din_dwen       (din_dwen),
      .din_done       (din_done),
      .din_tag        (din_tag),
      .dout           (dout),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .dout_dwen      (dout_dwen),
      .dout_last      (dout_last),
      .err_unexpected (err_unexpected)
`ifdef CPL_ROB_ERR_CNT_EN
      ,.err_count     (err_count)
`endif
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   logic [12:0] exp_q[$];   // {dwen, data byte, last}

   typedef struct {
      logic       av;
      logic [3:0] ab;
      logic       dv;
      logic [7:0] tag;
      logic [3:0] dwen;
      logic [7:0] db;
      logic [7:0] e_tag;
      logic       e_dv;
      logic       e_last;
      logic [3:0] e_dwen;
      logic [7:0] e_db;
      logic       e_err;
      logic [15:0] e_ecnt;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic av, input logic [3:0] ab, input logic dv,
                               input logic [7:0] tag, input logic [3:0] dwen, input logic [7:0] db,
                               input logic [7:0] e_tag, input logic e_dv, input logic e_last,
                               input logic [3:0] e_dwen, input logic [7:0] e_db, input logic e_err,
                               input logic [15:0] e_ecnt);
      vec_t v;
      v.av = av; v.ab = ab; v.dv = dv; v.tag = tag; v.dwen = dwen; v.db = db;
      v.e_tag = e_tag; v.e_dv = e_dv; v.e_last = e_last; v.e_dwen = e_dwen;
      v.e_db = e_db; v.e_err = e_err; v.e_ecnt = e_ecnt;
      return v;
   endfunction

   // scoreboard compare
   task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_idle();
      alloc_valid = 1'b0;
      alloc_beats = 4'd0;
      din_valid   = 1'b0;
      din         = '0;
      din_dwen    = 4'd0;
      din_done    = 1'b0;
      din_tag     = 8'd0;
   endtask

   task automatic drive_beat(input logic [7:0] tag, input logic [7:0] b, input logic [3:0] dw);
      din_valid = 1'b1;
      din_tag   = tag;
      din       = {16{b}};
      din_dwen  = dw;
      din_done  = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [131:0] held;
      logic [12:0]  got;
      logic [7:0]   b;
      int           pops;
      int           stall_left;
      bit           stalled_done;
      bit           have_held;

      tbl[0]  = mk(1, 4'd2, 0, 8'h00, 4'h0, 8'h00,  8'd0, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[1]  = mk(1, 4'd1, 0, 8'h00, 4'h0, 8'h00,  8'd1, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[2]  = mk(0, 4'd0, 1, 8'h01, 4'hF, 8'h10,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[3]  = mk(0, 4'd0, 1, 8'h00, 4'hF, 8'h00,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[4]  = mk(0, 4'd0, 1, 8'h00, 4'h3, 8'h01,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[5]  = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[6]  = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd2, 1, 0, 4'hF, 8'h00, 0, 16'd0);
      tbl[7]  = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd2, 1, 1, 4'h3, 8'h01, 0, 16'd0);
      tbl[8]  = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd2, 1, 1, 4'hF, 8'h10, 0, 16'd0);
      tbl[9]  = mk(0, 4'd0, 1, 8'h05, 4'hF, 8'h55,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd0);
      tbl[10] = mk(0, 4'd0, 1, 8'h10, 4'hF, 8'h66,  8'd2, 0, 0, 4'h0, 8'h00, 1, 16'd1);
      tbl[11] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd2, 0, 0, 4'h0, 8'h00, 1, 16'd2);
      tbl[12] = mk(1, 4'd3, 0, 8'h00, 4'h0, 8'h00,  8'd2, 0, 0, 4'h0, 8'h00, 0, 16'd2);
      tbl[13] = mk(0, 4'd0, 1, 8'h02, 4'hF, 8'h20,  8'd3, 0, 0, 4'h0, 8'h00, 0, 16'd2);
      tbl[14] = mk(0, 4'd0, 1, 8'h02, 4'hF, 8'h21,  8'd3, 0, 0, 4'h0, 8'h00, 0, 16'd2);
      tbl[15] = mk(0, 4'd0, 1, 8'h02, 4'h3, 8'h22,  8'd3, 0, 0, 4'h0, 8'h00, 0, 16'd2);
      tbl[16] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd3, 0, 0, 4'h0, 8'h00, 0, 16'd2);
      tbl[17] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd3, 1, 0, 4'hF, 8'h20, 0, 16'd2);
      tbl[18] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd3, 1, 0, 4'hF, 8'h21, 0, 16'd2);
      tbl[19] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd3, 1, 1, 4'h3, 8'h22, 0, 16'd2);
      tbl[20] = mk(0, 4'd0, 0, 8'h00, 4'h0, 8'h00,  8'd3, 0, 0, 4'h0, 8'h00, 0, 16'd2);

      // reset values
      i_rst = 1'b1;
      drive_idle();
      dout_ready = 1'b1;
      #12;
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_alloc_tag", alloc_tag, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_dwen", dout_dwen, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_err", err_unexpected, 0);
`ifdef CPL_ROB_ERR_CNT_EN
      check("rst_err_count", err_count, 0);
`endif
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();

      // vector table: reorder, drops, dwen / last placement
      for (int i = 0; i < NV; i++) begin
         alloc_valid = tbl[i].av;
         alloc_beats = tbl[i].ab;
         din_valid   = tbl[i].dv;
         din_tag     = tbl[i].tag;
         din_dwen    = tbl[i].dwen;
         din         = {16{tbl[i].db}};
         din_done    = tbl[i].dv;
         @(negedge i_clk);
         check($sformatf("v%0d_alloc_ready", i), alloc_ready, 1);
         check($sformatf("v%0d_alloc_tag", i), alloc_tag, tbl[i].e_tag);
         check($sformatf("v%0d_dout_valid", i), dout_valid, tbl[i].e_dv);
         check($sformatf("v%0d_err", i), err_unexpected, tbl[i].e_err);
         if (tbl[i].e_dv) begin
            check($sformatf("v%0d_dout", i), dout, {16{tbl[i].e_db}});
            check($sformatf("v%0d_dwen", i), dout_dwen, tbl[i].e_dwen);
            check($sformatf("v%0d_last", i), dout_last, tbl[i].e_last);
         end
`ifdef CPL_ROB_ERR_CNT_EN
         check($sformatf("v%0d_err_count", i), err_count, tbl[i].e_ecnt);
`endif
         tick();
      end
      drive_idle();

      // backpressure: alloc_beats 0 means a full 8-beat slot, stall 5 cycles mid-slot
      alloc_valid = 1'b1;
      alloc_beats = 4'd0;
      @(negedge i_clk);
      check("bp_alloc_tag", alloc_tag, 3);
      tick();
      drive_idle();
      for (int k = 0; k < 8; k++) begin
         b = 8'(8'h30 + k);
         drive_beat(8'h03, b, (k == 7) ? 4'h1 : 4'hF);
         exp_q.push_back({(k == 7) ? 4'h1 : 4'hF, b, (k == 7) ? 1'b1 : 1'b0});
         tick();
      end
      drive_idle();
      pops = 0;
      stall_left = 0;
      stalled_done = 0;
      have_held = 0;
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
         @(negedge i_clk);
         if (!dout_ready) begin
            if (!have_held) begin
               held = {dout_valid, dout_last, dout_dwen, dout[125:0]};
               have_held = 1;
               check("bp_valid_in_stall", dout_valid, 1);
            end else begin
               check("bp_hold", {dout_valid, dout_last, dout_dwen, dout[125:0]}, held);
            end
         end else if (dout_valid) begin
            got = {dout_dwen, dout[7:0], dout_last};
            check("bp_beat", got, exp_q.pop_front());
            pops++;
         end
         tick();
         if (pops == 3 && !stalled_done) begin
            dout_ready = 1'b0;
            stall_left = 5;
            stalled_done = 1;
         end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) dout_ready = 1'b1;
         end
      end
      check("bp_remaining", exp_q.size(), 0);
      check("bp_stalled", stalled_done, 1);
      @(negedge i_clk);
      check("bp_no_dup", dout_valid, 0);
      tick();

      // reset while streaming
      alloc_valid = 1'b1;
      alloc_beats = 4'd4;
      @(negedge i_clk);
      check("mr_alloc_tag", alloc_tag, 4);
      tick();
      drive_idle();
      for (int k = 0; k < 4; k++) begin
         drive_beat(8'h04, 8'(8'h40 + k), 4'hF);
         tick();
      end
      drive_idle();
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         if (dout_valid) break;
      end
      check("mr_streaming", dout_valid, 1);
      #2;
      i_rst = 1'b1;
      #1;
      check("mr_dout_valid", dout_valid, 0);
      check("mr_dout_last", dout_last, 0);
      check("mr_alloc_tag_rst", alloc_tag, 0);
      check("mr_alloc_ready_rst", alloc_ready, 1);
      tick();
      tick();
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();
      @(negedge i_clk);
      check("mr_post_tag", alloc_tag, 0);
      check("mr_post_ready", alloc_ready, 1);
      check("mr_post_valid", dout_valid, 0);
      tick();

      // full occupancy, drain tag 0, slot reuse
      dout_ready  = 1'b0;
      alloc_valid = 1'b1;
      alloc_beats = 4'd1;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         check($sformatf("full_tag%0d", i), alloc_tag, 8'(i));
         check($sformatf("full_ready%0d", i), alloc_ready, 1);
         tick();
      end
      @(negedge i_clk);
      check("full_ready_low", alloc_ready, 0);
      tick();
      alloc_valid = 1'b0;
      drive_beat(8'h00, 8'hA0, 4'hF);
      @(negedge i_clk);
      check("full_tag_blocked", alloc_tag, 0);
      check("full_err_clean", err_unexpected, 0);
      tick();
      drive_beat(8'h00, 8'hA1, 4'hF);
      @(negedge i_clk);
      check("full_err_before", err_unexpected, 0);
      tick();
      drive_idle();
      @(negedge i_clk);
      check("full_err_complete_slot", err_unexpected, 1);
      check("full_dout_valid", dout_valid, 1);
      check("full_dout", dout, {16{8'hA0}});
      tick();
      dout_ready = 1'b1;
      @(negedge i_clk);
      check("full_pop_valid", dout_valid, 1);
      check("full_pop_last", dout_last, 1);
      check("full_ready_at_pop", alloc_ready, 0);
      tick();
      @(negedge i_clk);
      check("full_ready_after", alloc_ready, 1);
      check("full_next_tag", alloc_tag, 0);
      check("full_no_dup", dout_valid, 0);
      tick();
      alloc_valid = 1'b1;
      @(negedge i_clk);
      check("reuse_ready", alloc_ready, 1);
      tick();
      drive_idle();
      @(negedge i_clk);
      check("reuse_tag", alloc_tag, 1);
      check("reuse_full", alloc_ready, 0);

      // report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
